writeback_stage: RTL and testbench

- Final pipeline stage, directly downstream of the memory stage.
- Accepts one completed instruction at a time over the standard stall/done handshake.
- Retires it by driving the register-file write port and bumping the retired-instruction counter.
- Latches a sticky halt on environment or illegal instructions; exposes last-retired PC and a forwarding view of the buffered result.

---
 rtl/writeback_stage_pkg.sv | 27 ++
 rtl/writeback_stage.sv | 97 +++++++++
 tb/tb_writeback_stage.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/writeback_stage_pkg.sv
// writeback_stage_pkg: shared pipeline widths and the bundle passed across stage boundaries.
package writeback_stage_pkg;
   localparam int ADDR_WIDTH = 32;
   localparam int DATA_WIDTH = 32;
   localparam int NUM_REGISTERS = 32;
   localparam int REGISTER_INDEXING_WIDTH = $clog2(NUM_REGISTERS);

   typedef struct packed {
      logic pc_valid;
      logic environment;
      logic opcode_legal;
      logic write_register_valid;
      logic result_data_valid;
   } wb_flags_t;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0]              pc;
      wb_flags_t                          flags;
      logic [REGISTER_INDEXING_WIDTH-1:0] write_register;
      logic [DATA_WIDTH-1:0]              result;
   } writeback_bundle_t;

   // Illegal opcodes and a write with no valid result both halt as faults.
   function automatic logic is_fault(wb_flags_t f);
      return !f.opcode_legal || (f.write_register_valid && !f.result_data_valid);
   endfunction
endpackage

// File: rtl/writeback_stage.sv
// writeback_stage: retires one buffered instruction per cycle into the register file,
// counts retirements and latches a sticky halt on environment calls or faults.
module writeback_stage
   import writeback_stage_pkg::*;
#(
   parameter int ADDR_WIDTH    = writeback_stage_pkg::ADDR_WIDTH,
   parameter int DATA_WIDTH    = writeback_stage_pkg::DATA_WIDTH,
   parameter int NUM_REGISTERS = writeback_stage_pkg::NUM_REGISTERS,
   parameter int COUNT_WIDTH   = 64,
   localparam int IW = $clog2(NUM_REGISTERS)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   output logic                   stall_prev,
   input  logic                   prev_done,
   input  logic                   hold,
   input  logic [ADDR_WIDTH-1:0]  program_count_in,
   input  logic                   program_count_valid_in,
   input  logic                   environment_in,
   input  logic                   opcode_legal_in,
   input  logic [IW-1:0]          write_register_in,
   input  logic                   write_register_valid_in,
   input  logic [DATA_WIDTH-1:0]  result_data_in,
   input  logic                   result_data_valid_in,
   output logic                   reg_write_en,
   output logic [IW-1:0]          reg_write_index,
   output logic [DATA_WIDTH-1:0]  reg_write_data,
   output logic                   fwd_valid,
   output logic [IW-1:0]          fwd_index,
   output logic [DATA_WIDTH-1:0]  fwd_data,
   output logic [COUNT_WIDTH-1:0] retired_count,
   output logic [ADDR_WIDTH-1:0]  last_pc,
   output logic                   halted,
   output logic                   halt_illegal
);
   logic                  has_input;
   logic [ADDR_WIDTH-1:0] buf_pc;
   wb_flags_t             buf_flags;
   logic [IW-1:0]         buf_reg;
   logic [DATA_WIDTH-1:0] buf_data;
   logic                  retire, halt_now, accept, writes;

   assign retire     = has_input && !hold && !halted;
   assign halt_now   = retire && (is_fault(buf_flags) || buf_flags.environment);
   assign stall_prev = !rst_n || halted || (has_input && !retire);
   // A halting retirement frees the buffer but must not pull in a successor.
   assign accept     = prev_done && !stall_prev && !halt_now;
   assign writes     = buf_flags.write_register_valid && buf_flags.result_data_valid &&
                       buf_flags.opcode_legal && buf_reg != '0;

   assign reg_write_en    = retire && writes && !buf_flags.environment;
   assign reg_write_index = buf_reg;
   assign reg_write_data  = buf_data;
   assign fwd_valid       = has_input && writes;
   assign fwd_index       = buf_reg;
   assign fwd_data        = buf_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         has_input     <= 1'b0;
         halted        <= 1'b0;
         halt_illegal  <= 1'b0;
         retired_count <= '0;
         last_pc       <= '0;
         buf_pc        <= '0;
         buf_flags     <= '0;
         buf_reg       <= '0;
         buf_data      <= '0;
      end else begin
         if (!has_input || retire) has_input <= accept;
         if (accept) begin
            buf_pc    <= program_count_in;
            buf_flags <= '{program_count_valid_in, environment_in, opcode_legal_in,
                           write_register_valid_in, result_data_valid_in};
            buf_reg   <= write_register_in;
            buf_data  <= result_data_in;
         end
         if (retire) begin
            if (!buf_flags.opcode_legal) begin
               halted       <= 1'b1;
               halt_illegal <= 1'b1;
            end else if (buf_flags.environment) begin
               retired_count <= retired_count + 1'b1;
               last_pc       <= buf_pc;
               halted        <= 1'b1;
               halt_illegal  <= 1'b0;
            end else if (buf_flags.write_register_valid && !buf_flags.result_data_valid) begin
               halted       <= 1'b1;
               halt_illegal <= 1'b1;
            end else begin
               retired_count <= retired_count + 1'b1;
               if (buf_flags.pc_valid) last_pc <= buf_pc;
            end
         end
      end
   end
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed vector table plus hand-written halt, reset and wrap sequences.
module tb_writeback_stage;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        stall_prev, prev_done, hold;
   logic [31:0] pc_in;
   logic        pcv_in, env_in, legal_in, wv_in, dv_in;
   logic [4:0]  idx_in;
   logic [31:0] data_in;
   logic        we, fwd_v, halted, halt_ill;
   logic [4:0]  w_idx, f_idx;
   logic [31:0] w_data, f_data, last_pc;
   logic [7:0]  count;
   int          n_cmp = 0, n_err = 0;

   always #5 clk = ~clk;

   writeback_stage #(.COUNT_WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .stall_prev(stall_prev), .prev_done(prev_done), .hold(hold),
      .program_count_in(pc_in), .program_count_valid_in(pcv_in), .environment_in(env_in),
      .opcode_legal_in(legal_in), .write_register_in(idx_in), .write_register_valid_in(wv_in),
      .result_data_in(data_in), .result_data_valid_in(dv_in), .reg_write_en(we),
      .reg_write_index(w_idx), .reg_write_data(w_data), .fwd_valid(fwd_v), .fwd_index(f_idx),
      .fwd_data(f_data), .retired_count(count), .last_pc(last_pc), .halted(halted),
      .halt_illegal(halt_ill)
   );

   typedef struct {
      logic pd, hd; logic [31:0] pc; logic env, legal, wv; logic [4:0] idx; logic [31:0] data;
      logic e_stall, e_we; logic [4:0] e_idx; logic [31:0] e_data; logic e_fwd;
      logic [7:0] e_cnt; logic [31:0] e_pc; logic e_halt, e_hi;
   } vec_t;

   function automatic vec_t v(logic pd, logic hd, logic [31:0] pc, logic env, logic legal,
                              logic wv, logic [4:0] idx, logic [31:0] data, logic e_stall,
                              logic e_we, logic [4:0] e_idx, logic [31:0] e_data, logic e_fwd,
                              logic [7:0] e_cnt, logic [31:0] e_pc, logic e_halt, logic e_hi);
      vec_t r;
      r = '{pd, hd, pc, env, legal, wv, idx, data, e_stall, e_we, e_idx, e_data, e_fwd,
            e_cnt, e_pc, e_halt, e_hi};
      return r;
   endfunction

   task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
      n_cmp++;
      if (a !== e) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, a, e);
      end
   endtask

   task automatic drive(logic pd, logic hd, logic [31:0] pc, logic env, logic legal, logic wv,
                        logic [4:0] idx, logic [31:0] data, logic dv);
      prev_done = pd; hold = hd; pc_in = pc; pcv_in = 1'b1; env_in = env;
      legal_in = legal; wv_in = wv; idx_in = idx; data_in = data; dv_in = dv;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   vec_t tbl[14];

   initial begin
      tbl[0]  = v(1,0,32'h10, 0,1,1,5,32'h11,   0,0,0,0,0,      0,32'h0,  0,0);
      tbl[1]  = v(1,0,32'h14, 0,1,1,6,32'h22,   0,1,5,32'h11,1, 0,32'h0,  0,0);
      tbl[2]  = v(1,0,32'h18, 0,1,1,0,32'hDEAD, 0,1,6,32'h22,1, 1,32'h10, 0,0);
      tbl[3]  = v(1,0,32'h1C, 0,1,1,7,32'h5,    0,0,0,0,0,      2,32'h14, 0,0);
      tbl[4]  = v(1,1,32'h20, 0,1,1,8,32'h8,    1,0,0,0,1,      3,32'h18, 0,0);
      tbl[5]  = tbl[4];
      tbl[6]  = tbl[4];
      tbl[7]  = v(1,0,32'h20, 0,1,1,8,32'h8,    0,1,7,32'h5,1,  3,32'h18, 0,0);
      tbl[8]  = v(0,0,32'h0,  0,1,0,0,32'h0,    0,1,8,32'h8,1,  4,32'h1C, 0,0);
      tbl[9]  = v(0,0,32'h0,  0,1,0,0,32'h0,    0,0,0,0,0,      5,32'h20, 0,0);
      tbl[10] = v(1,0,32'h100,1,1,0,0,32'h0,    0,0,0,0,0,      5,32'h20, 0,0);
      tbl[11] = v(0,0,32'h0,  0,1,0,0,32'h0,    0,0,0,0,0,      5,32'h20, 0,0);
      tbl[12] = v(1,0,32'h104,0,1,1,9,32'h99,   1,0,0,0,0,      6,32'h100,1,0);
      tbl[13] = tbl[12];

      drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
      #2 rst_n = 1'b0;
      @(negedge clk); #1;
      chk("rst_stall", stall_prev, 1); chk("rst_we", we, 0); chk("rst_fwd", fwd_v, 0);
      chk("rst_cnt", count, 0); chk("rst_halt", {halted, halt_ill}, 0); chk("rst_pc", last_pc, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 14; i++) begin
         if (i > 0) @(negedge clk);
         drive(tbl[i].pd, tbl[i].hd, tbl[i].pc, tbl[i].env, tbl[i].legal, tbl[i].wv,
               tbl[i].idx, tbl[i].data, 1'b1);
         #1;
         chk($sformatf("v%0d_stall", i), stall_prev, tbl[i].e_stall);
         chk($sformatf("v%0d_we", i), we, tbl[i].e_we);
         if (tbl[i].e_we) begin
            chk($sformatf("v%0d_widx", i), w_idx, tbl[i].e_idx);
            chk($sformatf("v%0d_wdata", i), w_data, tbl[i].e_data);
         end
         chk($sformatf("v%0d_fwd", i), fwd_v, tbl[i].e_fwd);
         chk($sformatf("v%0d_cnt", i), count, tbl[i].e_cnt);
         chk($sformatf("v%0d_lastpc", i), last_pc, tbl[i].e_pc);
         chk($sformatf("v%0d_halt", i), halted, tbl[i].e_halt);
         chk($sformatf("v%0d_hill", i), halt_ill, tbl[i].e_hi);
      end

      // Illegal opcode, illegal+environment, and write-without-result all halt as faults.
      for (int k = 0; k < 3; k++) begin
         do_reset();
         if (k == 0) drive(1, 0, 32'h200, 0, 0, 1, 3, 32'h1, 1);
         else if (k == 1) drive(1, 0, 32'h280, 1, 0, 1, 3, 32'h1, 1);
         else drive(1, 0, 32'h300, 0, 1, 1, 4, 32'h4, 0);
         @(negedge clk);
         drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
         #1;
         chk($sformatf("f%0d_we", k), we, 0);
         chk($sformatf("f%0d_fwd", k), fwd_v, 0);
         chk($sformatf("f%0d_stall", k), stall_prev, 0);
         @(negedge clk); #1;
         chk($sformatf("f%0d_halt", k), {halted, halt_ill}, 2'b11);
         chk($sformatf("f%0d_cnt", k), count, 0);
         chk($sformatf("f%0d_lastpc", k), last_pc, 0);
         chk($sformatf("f%0d_stall_h", k), stall_prev, 1);
      end

      // Reset asserted while the buffer holds an instruction.
      do_reset();
      drive(1, 0, 32'h400, 0, 1, 1, 10, 32'hAA, 1);
      @(negedge clk);
      drive(1, 0, 32'h404, 0, 1, 1, 11, 32'hBB, 1);
      #1 chk("mr_we1", {we, w_idx}, {1'b1, 5'd10});
      @(negedge clk); #1;
      chk("mr_we2", {we, w_idx}, {1'b1, 5'd11});
      chk("mr_cnt1", count, 1);
      rst_n = 1'b0;
      #1;
      chk("mr_we", we, 0); chk("mr_fwd", fwd_v, 0); chk("mr_stall", stall_prev, 1);
      chk("mr_cnt", count, 0); chk("mr_lastpc", last_pc, 0); chk("mr_halt", halted, 0);
      @(negedge clk); #1;
      chk("mr_we_hold", we, 0);
      rst_n = 1'b1;

      // 256 retirements wrap the 8-bit counter back to zero.
      do_reset();
      drive(1, 0, 32'h500, 0, 1, 1, 1, 32'h1, 1);
      repeat (256) @(posedge clk);
      @(negedge clk);
      #1 chk("wrap_255", count, 8'hFF);
      drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
      @(negedge clk); #1;
      chk("wrap_0", count, 0);
      chk("wrap_idle", {we, stall_prev}, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
